alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 5 +
 rtl/alu_regfile.sv | 37 +++
 rtl/alu_seq.sv | 102 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op encodings and controller state encoding shared by alu_seq and its bench.
package alu_pkg;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11} alu_op_e;
    typedef enum logic [1:0] {IDLE = 2'b00, READ = 2'b01, EXEC = 2'b10, WB = 2'b11} state_e;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 16-bit register file with two operand reads, one external read,
// and an external write plus a writeback write that takes priority on the same address.
module alu_regfile #(
    parameter int NREG = 8,
    parameter int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ext_en,
    input  logic [AW-1:0] ext_addr,
    input  logic [15:0]   ext_data,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [15:0]   wb_data,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [15:0]   rd0,
    output logic [15:0]   rd1,
    output logic [15:0]   rd2
);
    logic [15:0] r [NREG];

    // The writeback assignment comes last so it overrides the external write on a clash.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r <= '{default: '0};
        end else begin
            if (ext_en) r[ext_addr] <= ext_data;
            if (wb_en) r[wb_addr] <= wb_data;
        end
    end

    assign rd0 = r[ra0];
    assign rd1 = r[ra1];
    assign rd2 = r[ra2];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: four-state sequencer feeding an external ALU from a register file and writing back.
// Define ALU_SEQ_ZFLAG_EN to add the flag_z (result == 0) output.
module alu_seq
    import alu_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    output logic [1:0]    alu_op,
    output logic [15:0]   alu_i0,
    output logic [15:0]   alu_i1,
    input  logic [15:0]   alu_o,
    input  logic          alu_cout,
    output logic          done,
    output logic          flag_c
`ifdef ALU_SEQ_ZFLAG_EN
    ,
    output logic          flag_z
`endif
);
    state_e        state, next;
    alu_op_e       op_q;
    logic [AW-1:0] rd_q, rs1_q, rs2_q;
    logic [15:0]   src0, src1, res;
    logic          res_c;

    alu_regfile #(.NREG(NREG), .AW(AW)) u_rf (
        .clk(clk), .reset(reset),
        .ext_en(wr_en), .ext_addr(wr_addr), .ext_data(wr_data),
        .wb_en(state == WB), .wb_addr(rd_q), .wb_data(res),
        .ra0(rs1_q), .ra1(rs2_q), .ra2(rd_addr),
        .rd0(src0), .rd1(src1), .rd2(rd_data)
    );

    assign in_ready = state == IDLE;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = in_valid ? READ : IDLE;
            READ:    next = EXEC;
            EXEC:    next = WB;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= ALU_ADD;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            alu_op <= '0;
            alu_i0 <= '0;
            alu_i1 <= '0;
            res    <= '0;
            res_c  <= 1'b0;
            done   <= 1'b0;
            flag_c <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
            flag_z <= 1'b0;
`endif
        end else begin
            state <= next;
            if (in_valid && in_ready) begin
                op_q  <= alu_op_e'(in_op);
                rd_q  <= in_rd;
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
            end
            if (state == READ) begin
                alu_op <= op_q;
                alu_i0 <= src0;
                alu_i1 <= src1;
            end
            if (state == EXEC) begin
                res   <= alu_o;
                res_c <= alu_cout;
            end
            done <= state == WB;
            // Logic ops leave the carry from the last add/sub untouched.
            if (state == WB && (op_q == ALU_ADD || op_q == ALU_SUB)) flag_c <= res_c;
`ifdef ALU_SEQ_ZFLAG_EN
            if (state == WB) flag_z <= res == 16'h0000;
`endif
        end
    end
endmodule
